// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl: UART command parser driving core halt, counted stepping, timed soft reset and joypad override
`timescale 1ns/1ps
module uart_debug_ctrl #(
  parameter int KEY_WIDTH = 8,
  parameter int RST_CYCLES = 256,
  parameter int TIMEOUT = 1200000,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  output logic                 tx_valid,
  output logic [7:0]           tx_byte,
  input  logic                 tx_ready,
  input  logic                 core_tick,
  output logic                 halt,
  output logic                 core_rst,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 busy
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ARG, STEP, RESET, RESP} state_t;
  state_t state, state_nx;
  logic halt_nx, core_rst_nx, tx_valid_nx, ovr_en, ovr_en_nx, op_key, op_key_nx, rep;
  logic [7:0] tx_byte_nx, rep_byte, step_cnt, step_cnt_nx;
  logic [KEY_WIDTH-1:0] ovr_val, ovr_val_nx;
  logic [RW-1:0] rst_cnt, rst_cnt_nx;
  logic [TW-1:0] to_cnt, to_cnt_nx;
  assign key_out = ovr_en ? ovr_val : key_in;
  assign busy = state != IDLE;
  // register every piece of controller state; reset drops core_rst and discards any pending reply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      halt     <= HALT_ON_RESET;
      core_rst <= 1'b0;
      tx_valid <= 1'b0;
      tx_byte  <= 8'h00;
      ovr_en   <= 1'b0;
      ovr_val  <= '0;
      op_key   <= 1'b0;
      step_cnt <= 8'd0;
      rst_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nx;
      halt     <= halt_nx;
      core_rst <= core_rst_nx;
      tx_valid <= tx_valid_nx;
      tx_byte  <= tx_byte_nx;
      ovr_en   <= ovr_en_nx;
      ovr_val  <= ovr_val_nx;
      op_key   <= op_key_nx;
      step_cnt <= step_cnt_nx;
      rst_cnt  <= rst_cnt_nx;
      to_cnt   <= to_cnt_nx;
    end
  end
  // decode commands per state; any reply loads the tx register and parks in RESP on the same edge
  always_comb begin
    state_nx    = state;
    halt_nx     = halt;
    core_rst_nx = core_rst;
    tx_valid_nx = tx_valid;
    tx_byte_nx  = tx_byte;
    ovr_en_nx   = ovr_en;
    ovr_val_nx  = ovr_val;
    op_key_nx   = op_key;
    step_cnt_nx = step_cnt;
    rst_cnt_nx  = rst_cnt;
    to_cnt_nx   = to_cnt;
    rep         = 1'b0;
    rep_byte    = 8'h00;
    case (state)
      IDLE: if (rx_valid) begin
        case (rx_byte)
          8'h48: begin halt_nx = 1'b1; rep = 1'b1; rep_byte = 8'h4B; end
          8'h52: begin halt_nx = 1'b0; rep = 1'b1; rep_byte = 8'h4B; end
          8'h53, 8'h4B: begin
            op_key_nx = rx_byte == 8'h4B;
            to_cnt_nx = '0;
            state_nx  = ARG;
          end
          8'h6B: begin ovr_en_nx = 1'b0; rep = 1'b1; rep_byte = 8'h4B; end
          8'h58: begin
            core_rst_nx = 1'b1;
            rst_cnt_nx  = RW'(RST_CYCLES);
            state_nx    = RESET;
          end
          8'h3F: begin rep = 1'b1; rep_byte = {4'h5, ovr_en, core_rst, 1'b0, halt}; end
          default: begin rep = 1'b1; rep_byte = 8'h45; end
        endcase
      end
      ARG: if (rx_valid) begin
        if (op_key) begin
          ovr_val_nx = KEY_WIDTH'(rx_byte);
          ovr_en_nx  = 1'b1;
          rep        = 1'b1;
          rep_byte   = 8'h4B;
        end else if (rx_byte == 8'h00) begin
          rep      = 1'b1;
          rep_byte = 8'h4B;
        end else begin
          step_cnt_nx = rx_byte;
          halt_nx     = 1'b0;
          state_nx    = STEP;
        end
      end else if (to_cnt == TW'(TIMEOUT - 1)) begin
        to_cnt_nx = TW'(TIMEOUT);
        rep       = 1'b1;
        rep_byte  = 8'h45;
      end else begin
        to_cnt_nx = to_cnt + 1'b1;
      end
      STEP: begin
        step_cnt_nx = (core_tick && step_cnt != 8'd0) ? step_cnt - 8'd1 : step_cnt;
        if ((core_tick && step_cnt == 8'd1) || (rx_valid && rx_byte == 8'h48)) begin
          halt_nx  = 1'b1;
          rep      = 1'b1;
          rep_byte = 8'h4B;
        end
      end
      RESET: begin
        rst_cnt_nx = (rst_cnt != '0) ? rst_cnt - 1'b1 : rst_cnt;
        if (rst_cnt <= RW'(1)) begin
          core_rst_nx = 1'b0;
          rep         = 1'b1;
          rep_byte    = 8'h4B;
        end
      end
      RESP: if (tx_ready) begin
        tx_valid_nx = 1'b0;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (rep) begin
      tx_valid_nx = 1'b1;
      tx_byte_nx  = rep_byte;
      state_nx    = RESP;
    end
  end
endmodule

// File: tb/tb_uart_debug_ctrl.sv
// tb_uart_debug_ctrl: randomized command bench against a transaction-level model of the debug controller
`timescale 1ns/1ps
module tb_uart_debug_ctrl;
  localparam int KW = 8;
  localparam int RC = 256;
  localparam int TO = 100;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0, core_tick = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [KW-1:0] key_in = '0;
  logic tx_valid, halt, core_rst, busy;
  logic [7:0] tx_byte;
  logic [KW-1:0] key_out;
  int total = 0, bad = 0;
  bit quiet = 1'b0, rdy_force = 1'b0;
  logic [7:0] q[$];
  logic m_halt = 1'b0, m_ovr_en = 1'b0;
  logic [7:0] m_ovr_val = 8'h00;
  uart_debug_ctrl #(.KEY_WIDTH(KW), .RST_CYCLES(RC), .TIMEOUT(TO), .HALT_ON_RESET(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_valid(tx_valid),
    .tx_byte(tx_byte), .tx_ready(tx_ready), .core_tick(core_tick), .halt(halt),
    .core_rst(core_rst), .key_in(key_in), .key_out(key_out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask
  task automatic wait_reply();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      cyc();
      n++;
    end
    if (q.size() != 0) begin
      chk("reply_timeout", 32'(q.size()), 0);
      q.delete();
    end
  endtask
  task automatic cmd(logic [7:0] c, logic [7:0] a);
    quiet = 1'b0;
    if (c == 8'h48) begin m_halt = 1'b1; q.push_back(8'h4B); end
    else if (c == 8'h52) begin m_halt = 1'b0; q.push_back(8'h4B); end
    else if (c == 8'h6B) begin m_ovr_en = 1'b0; q.push_back(8'h4B); end
    else if (c == 8'h3F) q.push_back({4'h5, m_ovr_en, 1'b0, 1'b0, m_halt});
    else if (c == 8'h4B) begin m_ovr_en = 1'b1; m_ovr_val = a; q.push_back(8'h4B); end
    else if (c == 8'h53) q.push_back(8'h4B);
    else q.push_back(8'h45);
    send(c);
    if (c == 8'h4B || c == 8'h53) send(a);
    wait_reply();
    quiet = 1'b1;
  endtask
  task automatic lit(logic [7:0] c, logic [7:0] exp);
    quiet = 1'b0;
    q.push_back(exp);
    send(c);
    wait_reply();
    quiet = 1'b1;
  endtask
  task automatic step_run(int n, int mode, int k);
    quiet = 1'b0;
    m_halt = 1'b1;
    q.push_back(8'h4B);
    send(8'h53);
    send(8'(n));
    chk("step_running", halt, 0);
    for (int i = 1; i <= n; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      if (mode == 1 && i == k + 1) begin
        send(8'h48);
        chk("abort_halt", halt, 1);
        chk("abort_tx", tx_valid, 1);
        break;
      end
      core_tick = 1'b1;
      if (mode == 2 && i == n) begin rx_byte = 8'h48; rx_valid = 1'b1; end
      cyc();
      core_tick = 1'b0;
      rx_valid = 1'b0;
      chk("step_halt", halt, 32'(i == n));
      chk("step_tx", tx_valid, 32'(i == n));
    end
    repeat (2) begin core_tick = 1'b1; cyc(); core_tick = 1'b0; end
    wait_reply();
    quiet = 1'b1;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    key_in = KW'($urandom);
    tx_ready = rdy_force ? 1'b0 : 1'($urandom_range(0, 1));
  end
  always @(negedge clk) if (rst_n) begin
    if (tx_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_reply: got %0h expected none at %0t", tx_byte, $time);
      end else begin
        chk("tx_byte", tx_byte, q[0]);
        chk("reply_halt", halt, m_halt);
        chk("reply_key_out", key_out, m_ovr_en ? m_ovr_val : key_in);
        chk("reply_busy", busy, 1);
        chk("reply_core_rst", core_rst, 0);
        if (tx_ready) void'(q.pop_front());
      end
    end else if (quiet) begin
      chk("idle_halt", halt, m_halt);
      chk("idle_key_out", key_out, m_ovr_en ? m_ovr_val : key_in);
      chk("idle_busy", busy, 0);
      chk("idle_core_rst", core_rst, 0);
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, lat;
    logic [7:0] b;
    @(negedge clk);
    chk("rst_halt", halt, 0);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_key_out", key_out, key_in);
    cyc();
    rst_n = 1'b1;
    cyc();
    quiet = 1'b1;
    cmd(8'h48, 8'h00);
    chk("h_halt", halt, 1);
    cmd(8'h52, 8'h00);
    chk("r_halt", halt, 0);
    step_run(3, 0, 0);
    cmd(8'h53, 8'h00);
    chk("s0_halt", halt, 1);
    step_run(16, 1, 2);
    step_run(16, 2, 0);
    cmd(8'h52, 8'h00);
    quiet = 1'b0;
    q.push_back(8'h4B);
    send(8'h58);
    n = 0;
    while (core_rst === 1'b1 && n < RC + 20) begin
      if (n == 10) begin rx_byte = 8'h3F; rx_valid = 1'b1; end
      if (n == 20) begin rx_byte = 8'h48; rx_valid = 1'b1; end
      cyc();
      rx_valid = 1'b0;
      n++;
    end
    chk("rst_len", n, RC);
    wait_reply();
    quiet = 1'b1;
    chk("x_halt", halt, 0);
    cmd(8'h4B, 8'hA5);
    repeat (5) begin @(negedge clk); chk("ovr_key", key_out, 8'hA5); end
    cyc();
    lit(8'h3F, 8'h58);
    cmd(8'h6B, 8'h00);
    repeat (3) begin @(negedge clk); chk("live_key", key_out, key_in); end
    cyc();
    rdy_force = 1'b1;
    cyc();
    quiet = 1'b0;
    m_halt = 1'b1;
    q.push_back(8'h4B);
    send(8'h48);
    for (int i = 0; i < 50; i++) begin
      if (i % 10 == 0) send(8'h52); else cyc();
      chk("stall_valid", tx_valid, 1);
      chk("stall_byte", tx_byte, 8'h4B);
    end
    rdy_force = 1'b0;
    wait_reply();
    quiet = 1'b1;
    lit(8'h5A, 8'h45);
    quiet = 1'b0;
    q.push_back(8'h45);
    send(8'h53);
    lat = 0;
    while (!tx_valid && lat < TO + 50) begin cyc(); lat++; end
    chk("timeout_lat", lat, TO);
    wait_reply();
    quiet = 1'b1;
    chk("timeout_halt", halt, 1);
    quiet = 1'b0;
    m_ovr_en = 1'b1;
    m_ovr_val = 8'h3C;
    q.push_back(8'h4B);
    send(8'h4B);
    repeat (TO - 1) cyc();
    send(8'h3C);
    wait_reply();
    quiet = 1'b1;
    cmd(8'h6B, 8'h00);
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 7))
        0: cmd(8'h48, 8'h00);
        1: cmd(8'h52, 8'h00);
        2: cmd(8'h6B, 8'h00);
        3: cmd(8'h3F, 8'h00);
        4: cmd(8'h4B, 8'($urandom));
        5: cmd(8'h53, 8'h00);
        6: step_run($urandom_range(1, 8), 0, 0);
        default: begin
          do b = 8'($urandom); while (b inside {8'h48, 8'h52, 8'h53, 8'h4B, 8'h6B, 8'h58, 8'h3F});
          cmd(b, 8'h00);
        end
      endcase
    end
    quiet = 1'b0;
    send(8'h58);
    repeat (10) cyc();
    chk("midx_core_rst", core_rst, 1);
    rst_n = 1'b0;
    #1;
    chk("async_core_rst", core_rst, 0);
    chk("async_tx_valid", tx_valid, 0);
    chk("async_halt", halt, 0);
    chk("async_busy", busy, 0);
    m_halt = 1'b0;
    m_ovr_en = 1'b0;
    m_ovr_val = 8'h00;
    q.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    quiet = 1'b1;
    lit(8'h3F, 8'h50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
